// File: rtl/pdm_capture.sv
// pdm_capture
//   PDM microphone front end. Divides clock_i down to the microphone clock,
//   samples one (mono) or two (stereo, shared data line) PDM channels,
//   assembles WORD_LENGTH-bit words MSB first and presents complete frames on
//   a valid/ready handshake with a sticky overrun flag.
//
// Ports
//   clock_i      system clock, all logic on its rising edge
//   reset_n_i    synchronous active-low reset
//   enable_i     run control; low halts capture but holds the output frame
//   pdm_clk_o    microphone clock, SYSTEM_FREQUENCY/(2*H) with H the half period
//   pdm_data_i   PDM data line shared by both channels
//   data_o       frame; channel 0 in [WORD_LENGTH-1:0], channel 1 above it
//   valid_o      data_o holds an unconsumed frame
//   ready_i      consumer accepts the frame when valid_o is high
//   overrun_o    sticky: a completed frame was dropped
//   clear_i      clears overrun_o (a same-edge drop wins)
module pdm_capture #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int CHANNELS           = 1
) (
  input  logic                            clock_i,
  input  logic                            reset_n_i,
  input  logic                            enable_i,
  output logic                            pdm_clk_o,
  input  logic                            pdm_data_i,
  output logic [CHANNELS*WORD_LENGTH-1:0] data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            overrun_o,
  input  logic                            clear_i
);

  localparam int HALF    = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY / 2;
  localparam int CNT_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IDX_W   = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam int FRAME_W = CHANNELS * WORD_LENGTH;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  logic [CNT_W-1:0]       cnt_r;
  logic                   pdm_clk_r;
  logic [IDX_W-1:0]       bit_idx_r;
  logic [WORD_LENGTH-1:0] shift_r [CHANNELS];
  // Set by a channel 0 sample, cleared by the matching channel 1 sample, so
  // the low-phase terminal count before the first channel 0 bit is skipped.
  logic                   ch0_pending_r;
  // The last bit of a frame was captured on the previous edge.
  logic                   frame_done_r;
  logic [FRAME_W-1:0]     data_r;
  logic                   valid_r;
  logic                   overrun_r;

  logic                   terminal_s;
  logic                   ch0_sample_s;
  logic                   ch1_sample_s;
  logic                   last_sample_s;
  logic                   frame_complete_s;
  logic [CHANNELS-1:0]    sample_ch_s;
  logic [FRAME_W-1:0]     frame_s;
  logic                   load_s;
  logic                   drop_s;

  assign terminal_s       = enable_i && (cnt_r == CNT_LAST);
  assign ch0_sample_s     = terminal_s && pdm_clk_r;
  assign ch1_sample_s     = terminal_s && !pdm_clk_r && ch0_pending_r;
  assign last_sample_s    = (CHANNELS == 1) ? ch0_sample_s : ch1_sample_s;
  assign frame_complete_s = last_sample_s && (bit_idx_r == IDX_LAST);

  // A finished frame loads when the output slot is free or being emptied on
  // the same edge; otherwise it is dropped and flagged.
  assign load_s = frame_done_r && (!valid_r || ready_i);
  assign drop_s = frame_done_r && valid_r && !ready_i;

  // Per-channel sample strobes and frame assembly from the shift registers.
  always_comb begin
    sample_ch_s    = {CHANNELS{1'b0}};
    sample_ch_s[0] = ch0_sample_s;
    for (int c = 1; c < CHANNELS; c++) begin
      sample_ch_s[c] = ch1_sample_s;
    end
    frame_s = {FRAME_W{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      frame_s[c*WORD_LENGTH +: WORD_LENGTH] = shift_r[c];
    end
  end

  // Divider, bit sampling and frame assembly; disable discards a partial frame.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i || !enable_i) begin
      cnt_r         <= {CNT_W{1'b0}};
      pdm_clk_r     <= 1'b0;
      bit_idx_r     <= {IDX_W{1'b0}};
      ch0_pending_r <= 1'b0;
      frame_done_r  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        shift_r[c] <= {WORD_LENGTH{1'b0}};
      end
    end else begin
      if (cnt_r == CNT_LAST) begin
        cnt_r     <= {CNT_W{1'b0}};
        pdm_clk_r <= ~pdm_clk_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (sample_ch_s[c]) begin
          shift_r[c] <= {shift_r[c][WORD_LENGTH-2:0], pdm_data_i};
        end
      end

      if (ch0_sample_s) begin
        ch0_pending_r <= 1'b1;
      end else if (ch1_sample_s) begin
        ch0_pending_r <= 1'b0;
      end

      if (last_sample_s) begin
        if (bit_idx_r == IDX_LAST) begin
          bit_idx_r <= {IDX_W{1'b0}};
        end else begin
          bit_idx_r <= bit_idx_r + IDX_W'(1);
        end
      end

      frame_done_r <= frame_complete_s;
    end
  end

  // Output frame, handshake and sticky overrun; these hold while disabled.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      data_r    <= {FRAME_W{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load_s) begin
        data_r  <= frame_s;
        valid_r <= 1'b1;
      end else if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end

      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clear_i) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign pdm_clk_o = pdm_clk_r;
  assign data_o    = data_r;
  assign valid_o   = valid_r;
  assign overrun_o = overrun_r;

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: a mono and a stereo instance (WORD_LENGTH=8, H=5)
// checked every cycle against a behavioural model written from the timing
// rules (edge index k since enable), plus hand-computed literal expectations.
module tb_pdm_capture;

  localparam int WL = 8;
  localparam int H  = 5;
  localparam int P  = 2 * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0 drives the mono instance, index 1 the stereo instance.
  logic rn [2];
  logic en [2];
  logic din [2];
  logic rdy [2];
  logic clr [2];

  logic        pclk_m, valid_m, ovr_m;
  logic [7:0]  data_m;
  logic        pclk_s, valid_s, ovr_s;
  logic [15:0] data_s;

  pdm_capture #(.WORD_LENGTH(WL), .SYSTEM_FREQUENCY(100), .SAMPLING_FREQUENCY(10), .CHANNELS(1)) u_mono (
    .clock_i(clk), .reset_n_i(rn[0]), .enable_i(en[0]), .pdm_clk_o(pclk_m),
    .pdm_data_i(din[0]), .data_o(data_m), .valid_o(valid_m), .ready_i(rdy[0]),
    .overrun_o(ovr_m), .clear_i(clr[0])
  );

  pdm_capture #(.WORD_LENGTH(WL), .SYSTEM_FREQUENCY(100), .SAMPLING_FREQUENCY(10), .CHANNELS(2)) u_stereo (
    .clock_i(clk), .reset_n_i(rn[1]), .enable_i(en[1]), .pdm_clk_o(pclk_s),
    .pdm_data_i(din[1]), .data_o(data_s), .valid_o(valid_s), .ready_i(rdy[1]),
    .overrun_o(ovr_s), .clear_i(clr[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Mono frame f carries pats[f % 4], MSB first.
  logic [7:0] pats [4] = '{8'hB2, 8'h3C, 8'hE1, 8'h47};

  // Model state: m_k is the index of the next enabled edge.
  int m_k [2];
  int m_n [2];
  int m_w0 [2];
  int m_w1 [2];
  int m_frame [2];
  int m_data [2];
  bit m_load [2];
  bit m_valid [2];
  bit m_ovr [2];
  bit m_pclk [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    bit drop;
    int k;
    int mask;
    drop = 1'b0;
    mask = (1 << WL) - 1;
    if (rn[d] !== 1'b1) begin
      m_k[d] = 0; m_n[d] = 0; m_w0[d] = 0; m_w1[d] = 0; m_frame[d] = 0;
      m_data[d] = 0; m_load[d] = 1'b0; m_valid[d] = 1'b0; m_ovr[d] = 1'b0; m_pclk[d] = 1'b0;
    end else begin
      if (m_load[d]) begin
        if (!m_valid[d] || rdy[d] === 1'b1) begin
          m_data[d]  = m_frame[d];
          m_valid[d] = 1'b1;
        end else begin
          m_ovr[d] = 1'b1;
          drop     = 1'b1;
        end
      end else if (m_valid[d] && rdy[d] === 1'b1) begin
        m_valid[d] = 1'b0;
      end
      if (clr[d] === 1'b1 && !drop) m_ovr[d] = 1'b0;
      m_load[d] = 1'b0;
      if (en[d] !== 1'b1) begin
        m_k[d] = 0; m_n[d] = 0; m_w0[d] = 0; m_w1[d] = 0; m_pclk[d] = 1'b0;
      end else begin
        k = m_k[d];
        // Channel 0: last cycle of each high phase.
        if ((k + 1) % P == 0) begin
          m_w0[d] = ((m_w0[d] << 1) | int'(din[d])) & mask;
          if (d == 0) begin
            m_n[d]++;
            if (m_n[d] == WL) begin
              m_frame[d] = m_w0[d];
              m_load[d]  = 1'b1;
              m_n[d]     = 0;
            end
          end
        end
        // Channel 1: last cycle of each low phase, skipping the first one.
        if (d == 1 && (k + 1) % P == H && k + 1 > H) begin
          m_w1[d] = ((m_w1[d] << 1) | int'(din[d])) & mask;
          m_n[d]++;
          if (m_n[d] == WL) begin
            m_frame[d] = (m_w1[d] << WL) | m_w0[d];
            m_load[d]  = 1'b1;
            m_n[d]     = 0;
          end
        end
        m_pclk[d] = (((k + 1) / H) % 2) == 1;
        m_k[d]++;
      end
    end
  endtask

  // Advance the model on every active edge using the inputs the DUT sees.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("mono_pclk",    32'(pclk_m),  32'(m_pclk[0]));
      check("mono_valid",   32'(valid_m), 32'(m_valid[0]));
      check("mono_overrun", 32'(ovr_m),   32'(m_ovr[0]));
      check("mono_data",    32'(data_m),  32'(m_data[0]));
      check("st_pclk",      32'(pclk_s),  32'(m_pclk[1]));
      check("st_valid",     32'(valid_s), 32'(m_valid[1]));
      check("st_overrun",   32'(ovr_s),   32'(m_ovr[1]));
      check("st_data",      32'(data_s),  32'(m_data[1]));
    end
  end

  function automatic logic mono_bit(input int k);
    int s;
    logic [7:0] pat;
    s   = k / P;
    pat = pats[(s / WL) % 4];
    return pat[7 - (s % WL)];
  endfunction

  // One clock: inputs change 1 time unit after the edge, data set for next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    din[0] = mono_bit(m_k[0]);
    din[1] = m_pclk[1];
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (m_k[0] != target && guard < 2000) begin
      cyc();
      guard++;
    end
    if (guard >= 2000) check("wait_k_timeout", 32'(m_k[0]), 32'(target));
  endtask

  // Edges from (re)start until mono valid rises; -1 when it never does.
  task automatic mono_latency(output int edge_k);
    int cnt;
    cnt = 0;
    edge_k = -1;
    while (cnt < 200) begin
      cyc();
      cnt++;
      if (valid_m === 1'b1) begin
        edge_k = cnt - 1;
        break;
      end
    end
  endtask

  initial begin
    int fv0, fv1, pulses, lat;
    logic [7:0]  d0;
    logic [15:0] d1;
    bit seen0, seen1;

    for (int i = 0; i < 2; i++) begin
      rn[i] = 1'b0; en[i] = 1'b0; din[i] = 1'b0; rdy[i] = 1'b0; clr[i] = 1'b0;
    end
    run(3);
    chk_on = 1'b1;
    check("reset_valid",   32'(valid_m), 32'd0);
    check("reset_overrun", 32'(ovr_m),   32'd0);
    check("reset_data",    32'(data_m),  32'd0);
    check("reset_pclk",    32'(pclk_m),  32'd0);

    // Free-running capture in both modes with ready held high.
    for (int i = 0; i < 2; i++) begin
      rn[i] = 1'b1; en[i] = 1'b1; rdy[i] = 1'b1;
    end
    din[0] = mono_bit(0);
    din[1] = 1'b0;
    fv0 = -1; fv1 = -1; pulses = 0; seen0 = 1'b0; seen1 = 1'b0; d0 = 8'h00; d1 = 16'h0000;
    for (int i = 0; i < 175; i++) begin
      cyc();
      if (valid_m === 1'b1) pulses++;
      if (!seen0 && valid_m === 1'b1) begin seen0 = 1'b1; fv0 = m_k[0] - 1; d0 = data_m; end
      if (!seen1 && valid_s === 1'b1) begin seen1 = 1'b1; fv1 = m_k[1] - 1; d1 = data_s; end
    end
    check("mono_first_valid_edge", 32'(fv0), 32'd80);
    check("mono_first_data",       32'(d0),  32'hB2);
    check("mono_valid_pulses",     32'(pulses), 32'd2);
    check("st_first_valid_edge",   32'(fv1), 32'd85);
    check("st_first_data",         32'(d1),  32'h00FF);

    // Backpressure: first frame held, second dropped.
    en[0] = 1'b0; rdy[0] = 1'b0;
    run(2);
    en[0] = 1'b1;
    wait_k(165);
    check("bp_valid_held", 32'(valid_m), 32'd1);
    check("bp_data_held",  32'(data_m),  32'hB2);
    check("bp_overrun",    32'(ovr_m),   32'd1);
    rdy[0] = 1'b1;
    cyc();
    rdy[0] = 1'b0;
    check("bp_valid_fell",      32'(valid_m), 32'd0);
    check("bp_overrun_sticky",  32'(ovr_m),   32'd1);
    wait_k(241);
    check("bp_third_frame",     32'(data_m),  32'hE1);
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    check("bp_overrun_cleared", 32'(ovr_m),   32'd0);

    // Ready on the very edge a new frame loads: valid stays, data updates.
    wait_k(320);
    rdy[0] = 1'b1;
    cyc();
    rdy[0] = 1'b0;
    check("sim_valid_kept", 32'(valid_m), 32'd1);
    check("sim_data_new",   32'(data_m),  32'h47);
    check("sim_no_overrun", 32'(ovr_m),   32'd0);

    // Clear on the same edge as a drop: the drop wins.
    wait_k(400);
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    check("clr_drop_overrun", 32'(ovr_m),  32'd1);
    check("clr_drop_data",    32'(data_m), 32'h47);

    // Drain, restart, then disable at bit 4 of frame 1 with frame 0 pending.
    en[0] = 1'b0; rdy[0] = 1'b1;
    cyc();
    rdy[0] = 1'b0; en[0] = 1'b1;
    wait_k(130);
    en[0] = 1'b0;
    run(10);
    check("dis_pclk_low",   32'(pclk_m),  32'd0);
    check("dis_valid_held", 32'(valid_m), 32'd1);
    check("dis_data_held",  32'(data_m),  32'hB2);
    rdy[0] = 1'b1;
    cyc();
    rdy[0] = 1'b0;
    check("dis_drain", 32'(valid_m), 32'd0);
    en[0] = 1'b1;
    mono_latency(lat);
    check("reen_latency", 32'(lat),    32'd80);
    check("reen_data",    32'(data_m), 32'hB2);

    // One-cycle reset mid-frame with valid and overrun both set.
    wait_k(170);
    check("pre_reset_overrun", 32'(ovr_m), 32'd1);
    rn[0] = 1'b0;
    cyc();
    check("rst_valid",   32'(valid_m), 32'd0);
    check("rst_overrun", 32'(ovr_m),   32'd0);
    check("rst_data",    32'(data_m),  32'd0);
    check("rst_pclk",    32'(pclk_m),  32'd0);
    rn[0] = 1'b1;
    mono_latency(lat);
    check("rst_restart_latency", 32'(lat),    32'd80);
    check("rst_restart_data",    32'(data_m), 32'hB2);

    run(5);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_capture.md
# pdm_capture

Parametrised PDM microphone front end. It divides the system clock into the microphone clock and samples one or two PDM channels. Mono uses channel 0 only; stereo shares one data line, with channel 0 and channel 1 sampled on opposite clock phases. It assembles each channel's bits into a WORD_LENGTH-bit word and presents completed frames on a valid/ready handshake, with a sticky overrun flag. It sits between the PDM pins and the downstream decimation/filter stage.

## Interface
- WORD_LENGTH, 16, bits per channel word; must be ≥2.
- SYSTEM_FREQUENCY, 100000000, clock_i frequency in Hz.
- SAMPLING_FREQUENCY, 1000000, pdm_clk_o frequency in Hz.
- CHANNELS, 1, 1 = mono, 2 = stereo. Other values are illegal.
- clock_i  in  1  system clock; one clock domain, all logic on its rising edge.
- reset_n_i  in  1  reset; synchronous, active-low.
- enable_i  in  1  run control; while low, capture is halted.
- pdm_clk_o  out  1  microphone clock.
- pdm_data_i  in  1  PDM data line, shared by both channels.
- data_o  out  CHANNELS*WORD_LENGTH  frame; channel 0 in bits [WORD_LENGTH-1:0], channel 1 above it.
- valid_o  out  1  data_o holds an unconsumed frame.
- ready_i  in  1  consumer accepts the frame; a transfer occurs on any edge with valid_o & ready_i.
- overrun_o  out  1  sticky: at least one completed frame was dropped.
- clear_i  in  1  clears overrun_o.

## Operation
- H = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY/2, integer division.
  - H ≥ 2 is required.
  - The divider counter is $clog2(H) bits wide.
- Divider, on each enabled cycle:
  - If counter == H-1: counter ← 0 and pdm_clk_o toggles.
  - Otherwise: counter increments.
- Channel 0 sample: counter == H-1 and pdm_clk_o == 1, i.e. the last cycle before a falling edge.
- Channel 1 sample (stereo only): counter == H-1 and pdm_clk_o == 0, but only once a channel 0 bit is pending for the current bit index.
  - The first low-phase terminal count after enable is therefore ignored.
- Bits shift in MSB first: shift register ← {shift[WORD_LENGTH-2:0], pdm_data_i}.
- Bit index:
  - Counts 0..WORD_LENGTH-1.
  - Advances after the channel 0 sample (mono) or after the channel 1 sample (stereo).
  - Wraps to 0 at frame completion.
- Frame completion: the sample that writes bit index WORD_LENGTH-1 of the last channel. On the next edge:
  - If valid_o == 0 or ready_i == 1: data_o ← assembled words and valid_o ← 1.
  - Otherwise: the new frame is discarded, data_o and valid_o are unchanged, and overrun_o ← 1.
- valid_o falls on the edge after an accepted transfer, unless a new frame loads on that same edge; load has priority.
- overrun_o:
  - Clears on an edge with clear_i = 1.
  - A frame drop on the same edge wins, so overrun_o stays 1.
- enable_i low (reset_n_i high):
  - Divider counter, bit index and shift registers clear.
  - pdm_clk_o ← 0; any partial frame is discarded.
  - data_o, valid_o and overrun_o hold, so the consumer can still drain and acknowledge.
- reset_n_i low:
  - All state clears: pdm_clk_o = 0, data_o = 0, valid_o = 0, overrun_o = 0, counter = 0, bit index = 0.
  - Reset has priority over enable_i, ready_i and clear_i.
  - Reset mid-frame discards the frame. Capture restarts from bit 0 on the first enabled cycle after release.

## Timing
- Cycle k = 0 is the first rising edge with reset_n_i = 1 and enable_i = 1, starting from cleared divider state.
- pdm_clk_o first rises after edge k = H-1. Period is 2H cycles with 50% duty.
- Channel 0 bit n is sampled at edge k = 2H-1 + 2H·n (within frame 0).
- Channel 1 bit n is sampled at edge k = 3H-1 + 2H·n.
- Mono: valid_o is first high after edge k = 2H·WORD_LENGTH.
- Stereo: valid_o is first high after edge k = 2H·WORD_LENGTH + H.
- Frame period is 2H·WORD_LENGTH cycles in both modes, with no gap between frames.
- The consumer has exactly one frame period to accept a frame before an overrun occurs.
- Re-enable restarts the timing at k = 0.

## Test plan
- Mono, WORD_LENGTH=8, SYSTEM=100, SAMPLING=10 (H=5); pdm_data_i driven with bits 1,0,1,1,0,0,1,0 at the channel 0 sample points; ready_i=1 -> pdm_clk_o period 10 cycles; valid_o first high after edge 80; data_o=8'hB2; valid_o pulses for one cycle every 80 cycles.
- Stereo, same parameters; pdm_data_i=1 during high phases and 0 during low phases -> valid_o first high after edge 85; data_o=16'h00FF (channel 0 = FF, channel 1 = 00).
- Backpressure: mono with ready_i=0 for two frame periods -> first frame held in data_o; second frame dropped; overrun_o=1. Then ready_i=1 -> transfer; valid_o falls; overrun_o stays 1 until clear_i pulses.
- Simultaneous events: ready_i=1 on the edge a new frame loads -> valid_o stays 1 and data_o updates with no overrun. clear_i on a drop edge -> overrun_o=1.
- enable_i dropped at bit 4 of frame 1 with frame 0 pending -> pdm_clk_o=0; valid_o and data_o held. Re-enable -> next valid_o appears 80 cycles later, containing only new bits.
- reset_n_i low for 1 cycle mid-frame with valid_o=1 and overrun_o=1 -> all outputs 0 on the next edge; capture restarts at k=0 after release.
